wb_initiator: RTL
=================

// Module: wb_initiator
// PURPOSE
//  Wishbone classic single-transfer initiator (master) for user-area peripherals.
//  - Accepts one command at a time (valid/ready), runs one read or write cycle, returns one response (valid/ready).
//  - Bounded by a timeout counter, so a missing slave cannot hang the requester.
//  - Drives the user-area counter slave and similar WB slaves from LA- or FSM-driven test logic.
// PARAMETERS
//  TIMEOUT   16  cycles stb may stay high without ack before abort (>=2)
//  TO_BITS   5   width of the timeout counter; must hold TIMEOUT
//  ERR_DATA  32'hDEAD_BEEF  rsp_dat value returned on timeout
// PORTS
//  clk        in   1   clock
//  reset      in   1   reset, synchronous, active-high
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   high only in IDLE
//  cmd_we     in   1   1=write, 0=read
//  cmd_adr    in   32  byte address
//  cmd_dat    in   32  write data
//  cmd_sel    in   4   byte selects
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   response consumed
//  rsp_dat    out  32  read data; 0 for writes; ERR_DATA on timeout
//  rsp_err    out  1   1 = timed out
//  busy       out  1   state != IDLE
//  wbm_cyc_o  out  1   WB cycle
//  wbm_stb_o  out  1   WB strobe (always equals wbm_cyc_o)
//  wbm_we_o   out  1   WB write enable
//  wbm_sel_o  out  4   WB byte selects
//  wbm_adr_o  out  32  WB address
//  wbm_dat_o  out  32  WB write data
//  wbm_ack_i  in   1   WB acknowledge
//  wbm_dat_i  in   32  WB read data
// BEHAVIOUR
//  Reset values: rsp_valid, rsp_err, cyc, stb, we = 0; sel, adr, dat_o, rsp_dat = 0; cmd_ready = 1; state = IDLE.
//  Every output is registered, except cmd_ready and busy, which decode state.
//  FSM IDLE -> BUS -> RESP -> IDLE.
//  - IDLE: cmd_valid & cmd_ready at edge N
//      -> latch we/adr/dat/sel onto wbm_* regs
//      -> cyc = stb = 1 from cycle N+1
//      -> timeout count = 0; state = BUS.
//  - BUS: all wbm_* outputs hold stable; count increments each cycle.
//      - ack_i sampled high: cyc/stb drop next cycle; rsp_valid = 1, rsp_err = 0; state = RESP.
//        rsp_dat = wbm_dat_i for reads, 0 for writes.
//      - count == TIMEOUT-1 and no ack: cyc/stb drop next cycle; rsp_valid = 1, rsp_err = 1, rsp_dat = ERR_DATA; state = RESP.
//      - ack on the same cycle the timeout is reached: ack wins, no error.
//  - RESP: rsp_* hold stable until rsp_valid & rsp_ready.
//      - Then rsp_valid = 0 and state = IDLE.
//      - A new command is accepted no earlier than the cycle after the handshake; no back-to-back bypass.
//  Latency, with the one-cycle-ack counter slave (slave acks the cycle after it sees stb):
//    cmd accepted at N -> stb high N+1 -> ack high N+2 -> rsp_valid high N+3, cyc low N+3.
//  - ack_i in IDLE or RESP is ignored; it is a slave protocol error and must not corrupt state.
//  - cmd_valid while busy is not accepted (cmd_ready = 0); the command must be held by the source.
//  - Reset mid-cycle: cyc/stb low at the next edge; any pending response is discarded.
//  - wbm_adr_o is passed through unmodified (no alignment).
// STRUCTURE
//  Shared package (wb_pkg): state encoding localparams S_IDLE=2'd0, S_BUS=2'd1, S_RESP=2'd2;
//    WB_AW=32, WB_DW=32, WB_SELW=4; ERR_DATA default.
//  Sub-module wb_timeout_ctr (clear, enable, expired at TIMEOUT-1); everything else flat in wb_initiator.
// TESTING
//  1. Write adr 0x3000_0000, dat 0x0000_00A5, sel 4'hF to the counter slave -> one stb cycle with ack;
//     rsp_valid at N+3, rsp_err=0, rsp_dat=0; slave count restarts from 0xA5.
//  2. Read from the counter slave after test 1 -> rsp_dat equals the slave count at ack (0xA5 + elapsed);
//     cyc drops exactly one cycle after ack.
//  3. Read with ack tied low, TIMEOUT=16 -> stb high for exactly 16 cycles;
//     rsp_err=1, rsp_dat=0xDEAD_BEEF; the following command succeeds.
//  4. Back-pressure: rsp_ready low for 10 cycles -> rsp_valid/rsp_dat stable; cmd_ready=0 throughout;
//     IDLE the cycle after the handshake.
//  5. Ack asserted exactly on cycle TIMEOUT-1 -> rsp_err=0 with valid data; a stray ack in IDLE causes no response.
//  6. Assert reset on the 2nd cycle of BUS -> cyc/stb=0 and rsp_valid=0 at the next edge;
//     a new command then completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone initiator definitions: bus widths, FSM states, timeout response word.
package wb_pkg;
  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_SELW = 4;

  localparam logic [WB_DW-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles since clear, flags TIMEOUT-1.
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_BITS = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TO_BITS-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

  assign expired = (count == TO_BITS'(TIMEOUT - 1));
endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator with valid/ready command and
// response channels and a watchdog that aborts cycles the slave never acks.
module wb_initiator
  import wb_pkg::*;
#(
  parameter int unsigned      TIMEOUT  = 16,
  parameter int unsigned      TO_BITS  = 5,
  parameter logic [WB_DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [WB_AW-1:0]   cmd_adr,
  input  logic [WB_DW-1:0]   cmd_dat,
  input  logic [WB_SELW-1:0] cmd_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WB_DW-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic               busy,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [WB_SELW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [WB_DW-1:0]   wbm_dat_i
);
  state_t             state, state_n;
  logic               cyc_n, we_n, rsp_valid_n, rsp_err_n;
  logic [WB_SELW-1:0] sel_n;
  logic [WB_AW-1:0]   adr_n;
  logic [WB_DW-1:0]   dat_n, rsp_dat_n;
  logic               expired;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .TO_BITS (TO_BITS)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == S_IDLE),
    .enable  (state == S_BUS),
    .expired (expired)
  );

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign wbm_stb_o = wbm_cyc_o;

  always_comb begin
    state_n     = state;
    cyc_n       = wbm_cyc_o;
    we_n        = wbm_we_o;
    sel_n       = wbm_sel_o;
    adr_n       = wbm_adr_o;
    dat_n       = wbm_dat_o;
    rsp_valid_n = rsp_valid;
    rsp_err_n   = rsp_err;
    rsp_dat_n   = rsp_dat;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_n = S_BUS;
          cyc_n   = 1'b1;
          we_n    = cmd_we;
          sel_n   = cmd_sel;
          adr_n   = cmd_adr;
          dat_n   = cmd_dat;
        end
      end
      S_BUS: begin
        // Ack is tested first so an ack on the expiry cycle still completes cleanly.
        if (wbm_ack_i) begin
          state_n     = S_RESP;
          cyc_n       = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_dat_n   = wbm_we_o ? '0 : wbm_dat_i;
        end else if (expired) begin
          state_n     = S_RESP;
          cyc_n       = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_dat_n   = ERR_DATA;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_n     = S_IDLE;
          rsp_valid_n = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      state     <= state_n;
      wbm_cyc_o <= cyc_n;
      wbm_we_o  <= we_n;
      wbm_sel_o <= sel_n;
      wbm_adr_o <= adr_n;
      wbm_dat_o <= dat_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_dat   <= rsp_dat_n;
    end
  end
endmodule
